// File: rtl/png_pixel_packetizer.sv
// Packs decoded RGBA pixels into PKT_W-bit NIC packets: one assembly register plus one output register.
// Latency: 1 cycle from the closing pixel (or flush) to pkt_valid when the output register is free.
// Backpressure: pkt_ready stalls the output; a closed packet then waits, and pixels arriving meanwhile are dropped and counted.
module png_pixel_packetizer #(
    parameter int          PIX_PER_PKT = 16,
    parameter int          PKT_W       = 552,
    parameter logic [7:0]  MAGIC       = 8'hA5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             istart,
    input  logic             ivalid,
    input  logic [7:0]       ipixelr,
    input  logic [7:0]       ipixelg,
    input  logic [7:0]       ipixelb,
    input  logic [7:0]       ipixela,
    input  logic             flush,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic [PKT_W-1:0] pkt_data,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);
    localparam int CW = $clog2(PIX_PER_PKT + 1);
    localparam int BW = PKT_W - 40;

    typedef enum logic {FILL, WAIT} state_t;

    state_t        state, state_nxt;
    logic [31:0]   slot_q   [PIX_PER_PKT];
    logic [31:0]   slot_w   [PIX_PER_PKT];
    logic [31:0]   slot_nxt [PIX_PER_PKT];
    logic [CW-1:0] cnt_q, cnt_nxt, fill_cnt, hdr_cnt;
    logic [15:0]   seq_q, seq_nxt, drop_nxt;
    logic          first_q, first_nxt, last_q, last_nxt, ovf_nxt;
    logic          pkt_valid_nxt;
    logic [PKT_W-1:0] pkt_data_nxt;
    logic [BW-1:0] body;
    logic [31:0]   pix;
    logic [7:0]    hdr_flags;
    logic          wr, close, load, accept, out_free;

    assign pix      = {ipixelr, ipixelg, ipixelb, ipixela};
    assign wr       = (state == FILL) && ivalid;
    assign fill_cnt = cnt_q + CW'(wr);
    assign accept   = pkt_valid && pkt_ready;
    assign out_free = !pkt_valid || pkt_ready;
    assign close    = (state == FILL) &&
                      ((ivalid && cnt_q == CW'(PIX_PER_PKT - 1)) || (flush && fill_cnt != '0));

    // Assembly contents including this cycle's pixel, so a closing pixel lands in the packet.
    always_comb begin
        body = '0;
        for (int k = 0; k < PIX_PER_PKT; k++) begin
            slot_w[k] = (wr && cnt_q == CW'(k)) ? pix : slot_q[k];
            body[BW-1-32*k -: 32] = slot_w[k];
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt_q;
        seq_nxt       = seq_q;
        first_nxt     = first_q;
        last_nxt      = last_q;
        ovf_nxt       = overflow;
        drop_nxt      = drop_cnt;
        pkt_valid_nxt = pkt_valid;
        pkt_data_nxt  = pkt_data;
        slot_nxt      = slot_w;
        load          = 1'b0;
        hdr_cnt       = cnt_q;
        hdr_flags     = '0;

        if (accept)
            pkt_valid_nxt = 1'b0;

        if (istart) begin
            for (int k = 0; k < PIX_PER_PKT; k++)
                slot_nxt[k] = '0;
            if (ivalid)
                slot_nxt[0] = pix;
            cnt_nxt   = CW'(ivalid);
            seq_nxt   = '0;
            first_nxt = 1'b1;
            last_nxt  = 1'b0;
            ovf_nxt   = 1'b0;
            drop_nxt  = '0;
            state_nxt = FILL;
        end else if (state == FILL) begin
            cnt_nxt = fill_cnt;
            if (close) begin
                if (out_free) begin
                    load      = 1'b1;
                    hdr_cnt   = fill_cnt;
                    hdr_flags = {5'b0, overflow, flush, first_q};
                end else begin
                    state_nxt = WAIT;
                    last_nxt  = flush;
                end
            end
        end else begin
            // Assembly is frozen; every pixel here, even in the transfer cycle, is lost.
            if (ivalid) begin
                ovf_nxt = 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_nxt = drop_cnt + 16'd1;
            end
            if (accept) begin
                load      = 1'b1;
                hdr_flags = {5'b0, overflow | ivalid, last_q, first_q};
            end
        end

        if (load) begin
            pkt_valid_nxt = 1'b1;
            pkt_data_nxt  = {MAGIC, seq_q, 8'(hdr_cnt), hdr_flags, body};
            seq_nxt       = seq_q + 16'd1;
            first_nxt     = 1'b0;
            cnt_nxt       = '0;
            state_nxt     = FILL;
            for (int k = 0; k < PIX_PER_PKT; k++)
                slot_nxt[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FILL;
            cnt_q     <= '0;
            seq_q     <= '0;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            for (int k = 0; k < PIX_PER_PKT; k++)
                slot_q[k] <= '0;
        end else begin
            state     <= state_nxt;
            cnt_q     <= cnt_nxt;
            seq_q     <= seq_nxt;
            first_q   <= first_nxt;
            last_q    <= last_nxt;
            overflow  <= ovf_nxt;
            drop_cnt  <= drop_nxt;
            pkt_valid <= pkt_valid_nxt;
            pkt_data  <= pkt_data_nxt;
            for (int k = 0; k < PIX_PER_PKT; k++)
                slot_q[k] <= slot_nxt[k];
        end
    end
endmodule

// File: tb/tb_png_pixel_packetizer.sv
// Directed bench for png_pixel_packetizer: packet vector table plus hand sequences for backpressure, istart and reset.
module tb_png_pixel_packetizer;
    logic         clk = 1'b0;
    logic         rstn;
    logic         istart, ivalid, flush, pkt_ready;
    logic [7:0]   ipixelr, ipixelg, ipixelb, ipixela;
    logic         pkt_valid;
    logic [551:0] pkt_data;
    logic         overflow;
    logic [15:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    png_pixel_packetizer dut (
        .clk(clk), .rstn(rstn), .istart(istart), .ivalid(ivalid),
        .ipixelr(ipixelr), .ipixelg(ipixelg), .ipixelb(ipixelb), .ipixela(ipixela),
        .flush(flush), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_data(pkt_data), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          npix;
        logic [7:0]  base;
        int          fmode;      // 0 none, 1 flush next cycle, 2 flush with last pixel
        logic [39:0] hdr;
        logic [31:0] slot0;
        logic [31:0] slotl;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pv(input logic [7:0] b);
        return {b, 8'(b + 8'd1), 8'(b + 8'd2), 8'(b + 8'd3)};
    endfunction

    function automatic logic [31:0] slot(input int k);
        return pkt_data[511-32*k -: 32];
    endfunction

    task automatic send(input logic [7:0] b, input logic fl);
        ivalid = 1'b1;
        {ipixelr, ipixelg, ipixelb, ipixela} = pv(b);
        flush = fl;
        tick();
        ivalid = 1'b0;
        flush  = 1'b0;
    endtask

    vec_t vt [5];

    initial begin
        vt[0] = '{16, 8'h00, 0, 40'hA5_0000_10_01, 32'h00010203, 32'h0F101112};
        vt[1] = '{ 5, 8'h20, 1, 40'hA5_0001_05_02, 32'h20212223, 32'h24252627};
        vt[2] = '{ 3, 8'h40, 2, 40'hA5_0002_03_02, 32'h40414243, 32'h42434445};
        vt[3] = '{ 1, 8'h70, 1, 40'hA5_0003_01_02, 32'h70717273, 32'h70717273};
        vt[4] = '{16, 8'h80, 0, 40'hA5_0004_10_00, 32'h80818283, 32'h8F909192};

        rstn = 1'b0; istart = 1'b0; ivalid = 1'b0; flush = 1'b0; pkt_ready = 1'b1;
        {ipixelr, ipixelg, ipixelb, ipixela} = '0;
        tick(); tick();
        chk("rst_valid", 64'(pkt_valid), 64'd0);
        chk("rst_data",  64'(pkt_data[551:512]), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_drop",  64'(drop_cnt), 64'd0);
        rstn = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vt[v].npix; i++)
                send(8'(vt[v].base + 8'(i)), (vt[v].fmode == 2) && (i == vt[v].npix - 1));
            if (vt[v].fmode == 1) begin
                flush = 1'b1; tick(); flush = 1'b0;
            end
            chk($sformatf("v%0d_valid", v), 64'(pkt_valid), 64'd1);
            chk($sformatf("v%0d_hdr", v),   64'(pkt_data[551:512]), 64'(vt[v].hdr));
            chk($sformatf("v%0d_slot0", v), 64'(slot(0)), 64'(vt[v].slot0));
            chk($sformatf("v%0d_slotl", v), 64'(slot(vt[v].npix - 1)), 64'(vt[v].slotl));
            if (vt[v].npix < 16)
                chk($sformatf("v%0d_unused", v), 64'(slot(vt[v].npix)), 64'd0);
            tick();
            chk($sformatf("v%0d_drop_valid", v), 64'(pkt_valid), 64'd0);
        end

        // Flush with an empty assembly must not emit or consume a sequence number.
        flush = 1'b1; tick(); flush = 1'b0;
        chk("empty_flush", 64'(pkt_valid), 64'd0);

        // Close coincides with acceptance of the held packet: back-to-back, no wait, no drop.
        pkt_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) chk("b2b_held_hdr", 64'(pkt_data[551:512]), 64'hA5_0005_10_00);
            if (i == 15) pkt_ready = 1'b1;
            send(8'(8'h30 + 8'(i)), 1'b0);
        end
        chk("b2b_valid", 64'(pkt_valid), 64'd1);
        chk("b2b_hdr",   64'(pkt_data[551:512]), 64'hA5_0006_10_00);
        chk("b2b_slot0", 64'(slot(0)), 64'h30313233);
        chk("b2b_drop",  64'(drop_cnt), 64'd0);
        tick();
        chk("b2b_done", 64'(pkt_valid), 64'd0);

        // Stalled output: 40 pixels, second packet waits, last 8 dropped.
        istart = 1'b1; pkt_ready = 1'b0; tick(); istart = 1'b0;
        for (int i = 0; i < 40; i++) send(8'(i), 1'b0);
        chk("ovf_held_hdr",   64'(pkt_data[551:512]), 64'hA5_0000_10_01);
        chk("ovf_held_slot0", 64'(slot(0)), 64'h00010203);
        chk("ovf_flag",       64'(overflow), 64'd1);
        chk("ovf_drops",      64'(drop_cnt), 64'd8);
        pkt_ready = 1'b1; tick();
        chk("ovf_pkt1_valid", 64'(pkt_valid), 64'd1);
        chk("ovf_pkt1_hdr",   64'(pkt_data[551:512]), 64'hA5_0001_10_04);
        chk("ovf_pkt1_slot0", 64'(slot(0)), 64'h10111213);
        tick();
        chk("ovf_pkt1_gone",  64'(pkt_valid), 64'd0);
        send(8'h55, 1'b0);
        chk("ovf_fill_again", 64'(drop_cnt), 64'd8);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("ovf_pkt2_hdr",   64'(pkt_data[551:512]), 64'hA5_0002_01_06);
        tick();

        // istart with a pixel discards the partial packet and restarts the image.
        for (int i = 0; i < 7; i++) send(8'(8'h50 + 8'(i)), 1'b0);
        istart = 1'b1; ivalid = 1'b1;
        {ipixelr, ipixelg, ipixelb, ipixela} = 32'hAABBCCDD;
        tick();
        istart = 1'b0; ivalid = 1'b0;
        chk("istart_ovf",  64'(overflow), 64'd0);
        chk("istart_drop", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 15; i++) send(8'(8'h60 + 8'(i)), 1'b0);
        chk("istart_hdr",    64'(pkt_data[551:512]), 64'hA5_0000_10_01);
        chk("istart_slot0",  64'(slot(0)), 64'hAABBCCDD);
        chk("istart_slot1",  64'(slot(1)), 64'h60616263);
        chk("istart_slot15", 64'(slot(15)), 64'h6E6F7071);
        tick();

        // Asynchronous reset mid-assembly.
        for (int i = 0; i < 5; i++) send(8'(i), 1'b0);
        #2 rstn = 1'b0;
        #1 chk("arst_asm_valid", 64'(pkt_valid), 64'd0);
        #2 rstn = 1'b1;
        tick();

        // Asynchronous reset while a packet is held and another waits.
        pkt_ready = 1'b0;
        for (int i = 0; i < 33; i++) send(8'(i), 1'b0);
        chk("wait_pre_valid", 64'(pkt_valid), 64'd1);
        chk("wait_pre_ovf",   64'(overflow), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_wait_valid", 64'(pkt_valid), 64'd0);
        chk("arst_wait_data",  64'(pkt_data[551:480]), 64'd0);
        chk("arst_wait_ovf",   64'(overflow), 64'd0);
        chk("arst_wait_drop",  64'(drop_cnt), 64'd0);
        #2 rstn = 1'b1;
        pkt_ready = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        chk("post_rst_hdr",   64'(pkt_data[551:512]), 64'hA5_0000_10_01);
        chk("post_rst_slot0", 64'(slot(0)), 64'h00010203);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
